ascii_num_sep_ctrl: RTL
=======================

# ascii_num_sep_ctrl

Sequencer that turns a raw ASCII byte stream (e.g. UART RX) into a stream of signed 32-bit integers. It sits between the byte source and one `ascii_to_int32` converter instance. It splits the stream into tokens on separator characters and drives the converter's `start` / `char_valid` / `num_end` protocol. It returns each result on a valid/ready output, plus per-line number counts for the matrix-input path.

## Interface
Parameters:
- `MAX_CHARS`, 11: maximum characters per token, including a leading '-'.
- `WAIT_TIMEOUT`, 64: cycles to wait for converter `result_valid` before abandoning the token.

Ports (one clock; reset is asynchronous, active-low):
- `clk` in 1: clock.
- `rst_n` in 1: asynchronous active-low reset.
- `in_data` in 8: input ASCII byte.
- `in_valid` in 1: `in_data` is valid.
- `in_ready` out 1: block accepts `in_data` this cycle.
- `conv_start` out 1: one-cycle pulse, `start` to converter.
- `conv_char` out 8: character to converter.
- `conv_char_valid` out 1: one-cycle pulse, `char_valid` to converter.
- `conv_num_end` out 1: one-cycle pulse, `num_end` to converter.
- `conv_result` in 32: converter `result`, signed.
- `conv_result_valid` in 1: converter `result_valid`.
- `num_data` out 32: parsed signed integer.
- `num_valid` out 1: `num_data` is valid; held until accepted.
- `num_ready` in 1: downstream accepts `num_data`.
- `line_done` out 1: one-cycle pulse, end of line (LF) processed.
- `line_len` out 16: numbers emitted in the finished line; valid with `line_done`.
- `err` out 1: one-cycle pulse on any protocol or format error.

## Operation
- Byte classes:
  - DIGIT: '0'–'9'.
  - MINUS: 0x2D.
  - SEP: 0x20, 0x2C, 0x09, 0x0D.
  - EOL: 0x0A.
  - Everything else is INVALID.
- A byte is consumed on `in_valid && in_ready`. `in_ready` = 1 in IDLE and FEED only.
- All outputs are registered.
- States:
  - IDLE:
    - SEP is consumed and ignored.
    - EOL is consumed: `line_done` pulses with `line_len` = line counter, then the counter clears. An empty line gives `line_len` = 0.
    - DIGIT or MINUS: latch char, char count = 1, go to START.
    - INVALID: pulse `err`, drop the byte.
  - START: `conv_start` = 1 for one cycle → FIRST.
  - FIRST: `conv_char_valid` = 1 with the latched char → FEED.
  - FEED:
    - DIGIT: forward it (`conv_char_valid` pulse next cycle), count+1.
    - DIGIT when count = `MAX_CHARS`: drop, pulse `err`, stay in FEED.
    - MINUS or INVALID: drop, pulse `err`.
    - SEP: `conv_num_end` pulse next cycle → WAIT.
    - EOL: same as SEP, and set `pending_eol`.
  - WAIT:
    - On `conv_result_valid`: capture `conv_result` into `num_data`, set `num_valid`, line counter+1 (saturates at 0xFFFF), → OUT.
    - After `WAIT_TIMEOUT` cycles with no result: pulse `err`, clear `pending_eol` → IDLE. No number is emitted.
  - OUT: hold `num_valid` and `num_data` stable until `num_ready`. On the handshake, drop `num_valid`.
    - If `pending_eol`: pulse `line_done` (`line_len` includes this number), clear counter and `pending_eol`.
    - Go to IDLE.
- `conv_result_valid` outside WAIT is ignored.
- A lone "-" token is passed to the converter unchanged; whatever it returns (0) is emitted.
- The block does no arithmetic on values; `num_data` is exactly `conv_result`.

## Timing
- Reset values:
  - All outputs 0: `in_ready`, `num_valid`, all `conv_*`, `line_done`, `err`, `num_data`, `line_len`.
  - State IDLE, counters and `pending_eol` clear.
  - `in_ready` rises the first cycle after reset release.
- Reset mid-token: everything returns to the reset state immediately. The converter must restart on its next `conv_start`.
- Throughput: one byte per cycle in FEED. IDLE costs 2 cycles (START, FIRST) per token start with `in_ready` = 0.
- Latency:
  - Separator accepted at cycle T → `conv_num_end` at T+1.
  - Converter `result_valid` at T+1+L → `num_valid` at T+2+L.
- `num_valid` is never deasserted without `num_ready`.
- The cycle after an OUT handshake is IDLE with `in_ready` = 1.
- `err` and a pulse of `conv_*` or `line_done` may coincide. `err` does not change the state, except on timeout.

## Test plan
- "12 -34,5\n" with `num_ready` = 1:
  - `num_data` sequence 12, −34, 5.
  - `line_done` once with `line_len` = 3.
  - Converter sees exactly 3 `conv_start` and 3 `conv_num_end`.
- "2147483647 -2147483648\n":
  - Outputs 0x7FFFFFFF, then 0x80000000.
  - `line_len` = 2.
- Backpressure: "7 8\n" with `num_ready` low for 20 cycles after first `num_valid`:
  - `num_data` = 7 held stable and `in_ready` = 0 throughout.
  - Then 8 follows, then `line_done` (`line_len` = 2).
- Errors:
  - "1a2 3-4\n" → outputs 12, 34; `err` pulses twice.
  - "123456789012 " (12 digits, `MAX_CHARS` = 11) → one `err`, converter receives only 11 chars.
- Line edge cases:
  - "\n\n" → two `line_done` pulses with `line_len` = 0.
  - "-\n" → output 0, `line_len` = 1.
- Timeout and reset:
  - Converter model never returns `result_valid` → `err` exactly `WAIT_TIMEOUT` cycles after entering WAIT, then IDLE, no `num_valid`.
  - Assert `rst_n` low mid-token ("98") → all outputs 0.
  - "5\n" after release → 5, `line_len` = 1.

Source files
------------

// File: rtl/ascii_num_sep_ctrl.sv
// ascii_num_sep_ctrl: splits an ASCII byte stream into numeric tokens, drives an
// ascii_to_int32 converter through start/char_valid/num_end, and returns each
// converted value on a valid/ready output together with per-line number counts.
module ascii_num_sep_ctrl #(
    parameter int MAX_CHARS    = 11,
    parameter int WAIT_TIMEOUT = 64
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [7:0]  in_data,
    input  logic        in_valid,
    output logic        in_ready,
    output logic        conv_start,
    output logic [7:0]  conv_char,
    output logic        conv_char_valid,
    output logic        conv_num_end,
    input  logic [31:0] conv_result,
    input  logic        conv_result_valid,
    output logic [31:0] num_data,
    output logic        num_valid,
    input  logic        num_ready,
    output logic        line_done,
    output logic [15:0] line_len,
    output logic        err
);

    localparam int CW = $clog2(MAX_CHARS + 1);
    localparam int WW = $clog2(WAIT_TIMEOUT + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_FIRST,
        S_FEED,
        S_WAIT,
        S_OUT
    } state_t;

    state_t      state_q, state_d;
    logic [CW-1:0] char_cnt_q, char_cnt_d;
    logic [WW-1:0] wait_cnt_q, wait_cnt_d;
    logic [15:0] line_cnt_q, line_cnt_d;
    logic        pending_eol_q, pending_eol_d;

    logic        in_ready_q, in_ready_d;
    logic        conv_start_q, conv_start_d;
    // conv_char doubles as the latch for the first character of a token
    logic [7:0]  conv_char_q, conv_char_d;
    logic        conv_char_valid_q, conv_char_valid_d;
    logic        conv_num_end_q, conv_num_end_d;
    logic [31:0] num_data_q, num_data_d;
    logic        num_valid_q, num_valid_d;
    logic        line_done_q, line_done_d;
    logic [15:0] line_len_q, line_len_d;
    logic        err_q, err_d;

    logic        accept;
    logic        is_digit, is_minus, is_sep, is_eol;

    // Classify the incoming byte
    always_comb begin
        is_digit = (in_data >= 8'h30) && (in_data <= 8'h39);
        is_minus = (in_data == 8'h2D);
        is_sep   = (in_data == 8'h20) || (in_data == 8'h2C) ||
                   (in_data == 8'h09) || (in_data == 8'h0D);
        is_eol   = (in_data == 8'h0A);
        accept   = in_valid && in_ready_q;
    end

    // Next-state and registered-output computation; pulses default low
    always_comb begin
        state_d           = state_q;
        char_cnt_d        = char_cnt_q;
        wait_cnt_d        = wait_cnt_q;
        line_cnt_d        = line_cnt_q;
        pending_eol_d     = pending_eol_q;
        conv_start_d      = 1'b0;
        conv_char_d       = conv_char_q;
        conv_char_valid_d = 1'b0;
        conv_num_end_d    = 1'b0;
        num_data_d        = num_data_q;
        num_valid_d       = num_valid_q;
        line_done_d       = 1'b0;
        line_len_d        = line_len_q;
        err_d             = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    if (is_sep) begin
                        // separators between tokens are skipped
                    end else if (is_eol) begin
                        line_done_d = 1'b1;
                        line_len_d  = line_cnt_q;
                        line_cnt_d  = '0;
                    end else if (is_digit || is_minus) begin
                        conv_char_d  = in_data;
                        char_cnt_d   = CW'(1);
                        conv_start_d = 1'b1;
                        state_d      = S_START;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            S_START: begin
                // start is high this cycle; present the latched char next
                conv_char_valid_d = 1'b1;
                state_d           = S_FIRST;
            end
            S_FIRST: begin
                state_d = S_FEED;
            end
            S_FEED: begin
                if (accept) begin
                    if (is_digit) begin
                        if (char_cnt_q == CW'(MAX_CHARS)) begin
                            err_d = 1'b1;
                        end else begin
                            conv_char_d       = in_data;
                            conv_char_valid_d = 1'b1;
                            char_cnt_d        = char_cnt_q + CW'(1);
                        end
                    end else if (is_sep || is_eol) begin
                        conv_num_end_d = 1'b1;
                        wait_cnt_d     = '0;
                        state_d        = S_WAIT;
                        if (is_eol) begin
                            pending_eol_d = 1'b1;
                        end
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            S_WAIT: begin
                if (conv_result_valid) begin
                    num_data_d  = conv_result;
                    num_valid_d = 1'b1;
                    if (line_cnt_q != 16'hFFFF) begin
                        line_cnt_d = line_cnt_q + 16'd1;
                    end
                    state_d = S_OUT;
                end else if (wait_cnt_q == WW'(WAIT_TIMEOUT - 1)) begin
                    // converter never answered: abandon the token
                    err_d         = 1'b1;
                    pending_eol_d = 1'b0;
                    state_d       = S_IDLE;
                end else begin
                    wait_cnt_d = wait_cnt_q + WW'(1);
                end
            end
            S_OUT: begin
                if (num_ready) begin
                    num_valid_d = 1'b0;
                    if (pending_eol_q) begin
                        line_done_d   = 1'b1;
                        line_len_d    = line_cnt_q;
                        line_cnt_d    = '0;
                        pending_eol_d = 1'b0;
                    end
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        in_ready_d = (state_d == S_IDLE) || (state_d == S_FEED);
    end

    // State and output registers with asynchronous active-low reset
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q           <= S_IDLE;
            char_cnt_q        <= '0;
            wait_cnt_q        <= '0;
            line_cnt_q        <= '0;
            pending_eol_q     <= 1'b0;
            in_ready_q        <= 1'b0;
            conv_start_q      <= 1'b0;
            conv_char_q       <= '0;
            conv_char_valid_q <= 1'b0;
            conv_num_end_q    <= 1'b0;
            num_data_q        <= '0;
            num_valid_q       <= 1'b0;
            line_done_q       <= 1'b0;
            line_len_q        <= '0;
            err_q             <= 1'b0;
        end else begin
            state_q           <= state_d;
            char_cnt_q        <= char_cnt_d;
            wait_cnt_q        <= wait_cnt_d;
            line_cnt_q        <= line_cnt_d;
            pending_eol_q     <= pending_eol_d;
            in_ready_q        <= in_ready_d;
            conv_start_q      <= conv_start_d;
            conv_char_q       <= conv_char_d;
            conv_char_valid_q <= conv_char_valid_d;
            conv_num_end_q    <= conv_num_end_d;
            num_data_q        <= num_data_d;
            num_valid_q       <= num_valid_d;
            line_done_q       <= line_done_d;
            line_len_q        <= line_len_d;
            err_q             <= err_d;
        end
    end

    assign in_ready        = in_ready_q;
    assign conv_start      = conv_start_q;
    assign conv_char       = conv_char_q;
    assign conv_char_valid = conv_char_valid_q;
    assign conv_num_end    = conv_num_end_q;
    assign num_data        = num_data_q;
    assign num_valid       = num_valid_q;
    assign line_done       = line_done_q;
    assign line_len        = line_len_q;
    assign err             = err_q;

endmodule
